// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and sizing helpers for the mux scan sequencer.
//   state_e   : scan FSM states (IDLE, SCAN)
//   sel_width : select width for a given channel count
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int NUM_CH_DEF = 8;
  localparam int DWELL_DEF  = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: combinational channel picker for the scan sequencer.
//   i_mask   : channel enables
//   i_sel    : current channel
//   o_next   : lowest enabled channel strictly above i_sel
//   o_lowest : lowest enabled channel overall
//   o_last   : no enabled channel above i_sel
module mux_scan_next_ch #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [SEL_W-1:0]  o_next,
  output logic [SEL_W-1:0]  o_lowest,
  output logic              o_last
);

  // Walk downwards so the final hit on each output is the lowest candidate.
  always_comb begin
    o_next   = '0;
    o_lowest = '0;
    o_last   = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) o_lowest = SEL_W'(i);
      if (i_mask[i] && (i > int'(i_sel))) begin
        o_next = SEL_W'(i);
        o_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans the enabled channels of an 8:1 mux in ascending order,
// holding each on sel for DWELL cycles, sampling mux_out at the end of the
// dwell, and publishing the whole scan as one snapshot with a valid pulse.
// Optional feature macro: MUX_SCAN_ABORT_EN (adds the abort input).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : request a scan (IDLE only)
//   continuous  : latched with start; auto-restart after each scan
//   ch_mask     : channel enables, latched with start
//   abort       : (MUX_SCAN_ABORT_EN) drop the current scan, back to IDLE
//   sel         : mux select
//   mux_out     : mux output, combinational from sel
//   sample      : last completed snapshot
//   valid       : one-cycle pulse when sample updates
//   busy        : scan in progress
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = sel_width(NUM_CH),
  parameter int DWELL  = DWELL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
`ifdef MUX_SCAN_ABORT_EN
  input  logic              abort,
`endif
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] sample,
  output logic              valid,
  output logic              busy
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_e            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic              r_cont, w_cont_nxt;
  logic [NUM_CH-1:0] r_shadow, w_shadow_nxt;
  logic [NUM_CH-1:0] r_sample, w_sample_nxt;
  logic              r_valid, w_valid_nxt;
  logic [NUM_CH-1:0] w_snap;
  logic [NUM_CH-1:0] w_pick_mask;
  logic [SEL_W-1:0]  w_next, w_lowest;
  logic              w_last;
  logic              w_abort;

`ifdef MUX_SCAN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // One picker serves both states: in IDLE it finds the first channel of the
  // incoming mask, in SCAN it walks the latched mask.
  assign w_pick_mask = (r_state == IDLE) ? ch_mask : r_mask;

  mux_scan_next_ch #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next_ch (
    .i_mask   (w_pick_mask),
    .i_sel    (r_sel),
    .o_next   (w_next),
    .o_lowest (w_lowest),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask;
    w_cont_nxt   = r_cont;
    w_shadow_nxt = r_shadow;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    // Shadow plus the channel being captured this edge, so the final channel
    // lands in the snapshot without an extra cycle.
    w_snap        = r_shadow;
    w_snap[r_sel] = mux_out;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (|ch_mask) begin
            w_state_nxt  = SCAN;
            w_mask_nxt   = ch_mask;
            w_cont_nxt   = continuous;
            w_sel_nxt    = w_lowest;
            w_cnt_nxt    = DWELL_M1;
            w_shadow_nxt = '0;
          end else begin
            w_sample_nxt = '0;
            w_valid_nxt  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
          w_sel_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_shadow_nxt = w_snap;
          if (!w_last) begin
            w_sel_nxt = w_next;
            w_cnt_nxt = DWELL_M1;
          end else begin
            w_sample_nxt = w_snap;
            w_valid_nxt  = 1'b1;
            if (r_cont) begin
              w_sel_nxt    = w_lowest;
              w_cnt_nxt    = DWELL_M1;
              w_shadow_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
              w_sel_nxt   = '0;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_cont   <= 1'b0;
      r_shadow <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_cont   <= w_cont_nxt;
      r_shadow <= w_shadow_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign sel    = r_sel;
  assign sample = r_sample;
  assign valid  = r_valid;
  assign busy   = (r_state == SCAN);

endmodule
